dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and off-chip data memory.
- It produces the stall signal that freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB while a miss is serviced.
- It returns read data to the MEM stage for the MEM_WB register.
- It is the responder to the MEM stage's load/store requests and the initiator of line transfers to data memory.

---
 rtl/dcache_controller.sv | 108 ++++++++++
 tb/tb_dcache_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller sitting between
// the MEM stage and off-chip data memory; stalls the pipeline while a miss is serviced.
module dcache_controller #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned LINES = 2 ** INDEX_W;
  localparam int unsigned TAG_W = 27 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESOLVE} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tags  [LINES];
  logic [255:0]       lines [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         word;
  logic [7:0]         bit_base;
  logic               hit;
  logic               idle_hit;
  logic               unused_byte_sel;

  assign idx             = cpu_addr_i[5+INDEX_W-1:5];
  assign tag             = cpu_addr_i[31:5+INDEX_W];
  assign word            = cpu_addr_i[4:2];
  assign bit_base        = {word, 5'b0};
  assign unused_byte_sel = ^cpu_addr_i[1:0];

  assign hit         = valid[idx] && (tags[idx] == tag);
  assign idle_hit    = (state == IDLE) && hit;
  assign cpu_stall_o = cpu_req_i && !idle_hit;
  assign cpu_data_o  = idle_hit ? lines[idx][bit_base +: 32] : 32'b0;

  // Miss-handling FSM; memory-side outputs follow the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= 32'b0;
      mem_data_o   <= 256'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_i) begin
            if (hit) begin
              if (cpu_write_i) begin
                lines[idx][bit_base +: 32] <= cpu_data_i;
                dirty[idx]                 <= 1'b1;
              end
            end else if (valid[idx] && dirty[idx]) begin
              state        <= WRITEBACK;
              mem_enable_o <= 1'b1;
              mem_write_o  <= 1'b1;
              mem_addr_o   <= {tags[idx], idx, 5'b0};
              mem_data_o   <= lines[idx];
            end else begin
              state        <= REFILL;
              mem_enable_o <= 1'b1;
              mem_write_o  <= 1'b0;
              mem_addr_o   <= {tag, idx, 5'b0};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state       <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag, idx, 5'b0};
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            lines[idx]   <= mem_data_i;
            tags[idx]    <= tag;
            valid[idx]   <= 1'b1;
            dirty[idx]   <= 1'b0;
            state        <= RESOLVE;
            mem_enable_o <= 1'b0;
          end
        end
        RESOLVE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: read-data scoreboard, a memory model that
// acks three cycles after enable rises, and stall/memory-traffic checks per access.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic         write;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_enable;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;
  logic         model_ack;
  logic         manual_ack;
  logic         auto_ack;

  int passed = 0;
  int total  = 0;
  int cnt    = 0;

  logic [31:0]  sb[$];
  logic [31:0]  shadow [int unsigned];
  logic         wb_seen, rf_seen, any_en;
  logic [31:0]  wb_addr, rf_addr;
  logic [255:0] wb_data;

  always #5 clk = ~clk;

  dcache_controller #(.INDEX_W(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (req),
    .cpu_write_i (write),
    .cpu_addr_i  (addr),
    .cpu_data_i  (wdata),
    .cpu_data_o  (rdata),
    .cpu_stall_o (stall),
    .mem_enable_o(mem_enable),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_data_i  (mem_rdata),
    .mem_ack_i   (mem_ack)
  );

  // Backing memory contents: word at byte address a is 0xDEADBEEF + a - 0x100.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hDEADBEEF + {a[31:2], 2'b00} - 32'h100;
  endfunction

  always_comb begin
    mem_rdata = '0;
    for (int w = 0; w < 8; w++)
      mem_rdata[w*32 +: 32] = mem_word({mem_addr[31:5], 5'b0} + 32'(w * 4));
  end

  assign mem_ack = model_ack | manual_ack;

  // Ack in the fourth cycle of each enabled transaction.
  always @(negedge clk) begin
    model_ack = 1'b0;
    if (auto_ack && mem_enable) begin
      cnt++;
      if (cnt == 4) begin
        model_ack = 1'b1;
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] expect_word(input logic [31:0] a);
    logic [31:0] wa = {a[31:2], 2'b00};
    return shadow.exists(wa) ? shadow[wa] : mem_word(wa);
  endfunction

  // Entered at posedge+1; returns at posedge+1 after the access completes.
  task automatic access(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int exp_stall,
                        input logic [31:0] exp_wb, input logic [31:0] exp_rf);
    int  stalls = 0;
    bit  done   = 0;
    wb_seen = 0; rf_seen = 0; any_en = 0;
    req = 1'b1; write = wr; addr = a; wdata = d;
    if (!wr) sb.push_back(expect_word(a));
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem_enable) any_en = 1'b1;
      if (mem_enable && mem_write && !wb_seen) begin
        wb_seen = 1'b1; wb_addr = mem_addr; wb_data = mem_wdata;
      end
      if (mem_enable && !mem_write && !rf_seen) begin
        rf_seen = 1'b1; rf_addr = mem_addr;
      end
      if (!stall) begin
        done = 1;
        break;
      end
      stalls++;
    end
    check({tag, "_done"}, 256'(done), 256'(1));
    check({tag, "_stall"}, 256'(stalls), 256'(exp_stall));
    if (!wr && sb.size() > 0) check({tag, "_rdata"}, 256'(rdata), 256'(sb.pop_front()));
    if (wr) shadow[{a[31:2], 2'b00}] = d;
    if (exp_rf == 32'b0) check({tag, "_no_mem"}, 256'(any_en), 256'(0));
    else check({tag, "_rf_addr"}, 256'(rf_addr), 256'(exp_rf));
    if (exp_wb != 32'b0) check({tag, "_wb_addr"}, 256'(wb_addr), 256'(exp_wb));
    else if (exp_rf != 32'b0) check({tag, "_no_wb"}, 256'(wb_seen), 256'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    manual_ack = 1'b0; auto_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_enable", 256'(mem_enable), 256'(0));
    check("rst_write", 256'(mem_write), 256'(0));
    check("rst_addr", 256'(mem_addr), 256'(0));
    check("rst_wdata", mem_wdata, 256'(0));
    check("rst_stall_idle", 256'(stall), 256'(0));
    check("rst_rdata", 256'(rdata), 256'(0));
    @(posedge clk); #1;

    access("rd100", 1'b0, 32'h100, '0, 6, 32'h0, 32'h100);
    check("rd100_value", 256'(rdata), 256'(32'hDEADBEEF));
    access("rd104", 1'b0, 32'h104, '0, 0, 32'h0, 32'h0);
    access("wr108", 1'b1, 32'h108, 32'h12345678, 0, 32'h0, 32'h0);
    access("rd108", 1'b0, 32'h108, '0, 0, 32'h0, 32'h0);
    access("rd300", 1'b0, 32'h300, '0, 10, 32'h100, 32'h300);
    check("wb_word2", 256'(wb_data[95:64]), 256'(32'h12345678));
    check("wb_word0", 256'(wb_data[31:0]), 256'(32'hDEADBEEF));
    access("rd500", 1'b0, 32'h500, '0, 6, 32'h0, 32'h500);
    req = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a refill, then a late ack.
    auto_ack = 1'b0;
    req = 1'b1; write = 1'b0; addr = 32'h700;
    rf_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_enable && !mem_write) begin
        rf_seen = 1'b1;
        break;
      end
    end
    check("mid_refill_seen", 256'(rf_seen), 256'(1));
    check("mid_stall", 256'(stall), 256'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("rst_mid_enable", 256'(mem_enable), 256'(0));
    check("rst_mid_addr", 256'(mem_addr), 256'(0));
    manual_ack = 1'b1;
    @(posedge clk); #1 manual_ack = 1'b0;
    @(negedge clk);
    check("late_ack_ignored", 256'(mem_enable), 256'(0));
    auto_ack = 1'b1;
    @(posedge clk); #1;
    shadow.delete();
    access("rd100_again", 1'b0, 32'h100, '0, 6, 32'h0, 32'h100);
    check("rd100_again_value", 256'(rdata), 256'(32'hDEADBEEF));
    req = 1'b0;
    @(negedge clk);
    check("idle_stall", 256'(stall), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
